// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/state helpers for the round controller.
// The AES_ABORT_EN macro, when defined, adds an abort input to aes_round_ctrl.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  // State indexed as [row][col]; byte i of a word maps to [i%4][i/4].
  typedef logic [3:0][3:0][7:0] aes_state_t;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // RCON[1:10]; out-of-range rounds return zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_state_t word_to_state(input logic [127:0] w);
    aes_state_t s;
    for (int i = 0; i < 16; i++) s[2'(i % 4)][2'(i / 4)] = w[7'(8 * (15 - i)) +: 8];
    return s;
  endfunction

  function automatic logic [127:0] state_to_word(input aes_state_t s);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[7'(8 * (15 - i)) +: 8] = s[2'(i % 4)][2'(i / 4)];
    return w;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rc,
  output logic [127:0] next_key_c
);
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  // SubWord(RotWord(w3)) with the round constant folded into the top byte.
  assign t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;
  assign next_key_c = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_stages.sv
// Combinational AES round stages: SubBytes, ShiftRows, MixColumns.
module aes_subbytes
  import aes_pkg::*;
(
  input  aes_state_t state,
  output aes_state_t result_c
);
  always_comb begin
    result_c = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        result_c[r][c] = sbox(state[r][c]);
  end
endmodule

module aes_shiftrows
  import aes_pkg::*;
(
  input  aes_state_t state,
  output aes_state_t result_c
);
  // Row r rotates left by r columns.
  always_comb begin
    result_c = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        result_c[r][c] = state[r][2'(c + r)];
  end
endmodule

module aes_mixcolumns
  import aes_pkg::*;
(
  input  aes_state_t state,
  output aes_state_t result_c
);
  always_comb begin
    result_c = '0;
    for (int c = 0; c < 4; c++) begin
      result_c[0][c] = xtime(state[0][c]) ^ xtime(state[1][c]) ^ state[1][c] ^ state[2][c] ^ state[3][c];
      result_c[1][c] = state[0][c] ^ xtime(state[1][c]) ^ xtime(state[2][c]) ^ state[2][c] ^ state[3][c];
      result_c[2][c] = state[0][c] ^ state[1][c] ^ xtime(state[2][c]) ^ xtime(state[3][c]) ^ state[3][c];
      result_c[3][c] = xtime(state[0][c]) ^ state[0][c] ^ state[1][c] ^ state[2][c] ^ xtime(state[3][c]);
    end
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor, one round per clock, one block in flight.
// Optional AES_ABORT_EN adds an abort input that discards the block in progress.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR    = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         busy
`ifdef AES_ABORT_EN
  ,
  input  logic         abort
`endif
);

  if (NR != AES_NR || CNT_W < $clog2(NR + 1)) begin : g_bad_cfg
    $error("aes_round_ctrl: only NR=10 with CNT_W>=4 is supported");
  end

  fsm_t             fsm;
  logic [127:0]     state_reg, key_reg;
  logic [CNT_W-1:0] rnd;

  aes_state_t   cur_c, sb_c, sr_c, mc_c;
  logic [127:0] rk_c, round_c;
  logic         last_c, abort_c;

  assign cur_c = word_to_state(state_reg);

  aes_subbytes   u_sb (.state(cur_c), .result_c(sb_c));
  aes_shiftrows  u_sr (.state(sb_c),  .result_c(sr_c));
  aes_mixcolumns u_mc (.state(sr_c),  .result_c(mc_c));
  aes_key_step   u_ks (.key(key_reg), .rc(rcon(4'(rnd))), .next_key_c(rk_c));

  // Final round skips MixColumns.
  assign last_c  = (rnd == CNT_W'(NR));
  assign round_c = state_to_word(last_c ? sr_c : mc_c) ^ rk_c;

`ifdef AES_ABORT_EN
  assign abort_c = abort && (fsm != S_IDLE);
`else
  assign abort_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_ct    <= '0;
      busy      <= 1'b0;
    end else if (abort_c) begin
      fsm       <= S_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= in_pt ^ in_key;
            key_reg   <= in_key;
            rnd       <= CNT_W'(1);
            fsm       <= S_ROUND;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        S_ROUND: begin
          state_reg <= round_c;
          key_reg   <= rk_c;
          rnd       <= rnd + CNT_W'(1);
          if (last_c) begin
            fsm       <= S_DONE;
            out_valid <= 1'b1;
            out_ct    <= round_c;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm       <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: known-answer vectors plus multi-cycle corner sequences.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_pt = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         busy;
`ifdef AES_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_ct(out_ct), .busy(busy)
`ifdef AES_ABORT_EN
    , .abort(abort)
`endif
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[5];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk_word(input string name, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_bit("accept_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_pt    = pt;
    in_key   = key;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles since the accept cycle until out_valid, then checks the result.
  task automatic wait_result(input string name, input logic [127:0] exp_ct, input bit churn);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      if (churn) begin
        in_pt  = {$urandom, $urandom, $urandom, $urandom};
        in_key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    chk_int({name, "_latency"}, lat, 11);
    chk_word({name, "_ct"}, out_ct, exp_ct);
    chk_bit({name, "_busy"}, busy, 1'b1);
    chk_bit({name, "_in_ready_low"}, in_ready, 1'b0);
  endtask

  task automatic take_result(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_bit({name, "_valid_drop"}, out_valid, 1'b0);
    chk_bit({name, "_idle_ready"}, in_ready, 1'b1);
    chk_bit({name, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;

    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                ct:  128'hf5d3d58503b9699de785895a96fdbaaf};

    // Reset state
    repeat (3) @(negedge clk);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_in_ready", in_ready, 1'b0);
    chk_word("rst_out_ct", out_ct, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("post_rst_in_ready", in_ready, 1'b1);

    // Known-answer vectors
    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].pt, vecs[i].key);
      wait_result($sformatf("vec%0d", i), vecs[i].ct, 1'b0);
      take_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held 20 cycles while a new block is offered and ignored
    accept(vecs[0].pt, vecs[0].key);
    wait_result("bp", vecs[0].ct, 1'b0);
    held     = out_ct;
    in_valid = 1'b1;
    in_pt    = vecs[1].pt;
    in_key   = vecs[1].key;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_bit("bp_hold_valid", out_valid, 1'b1);
      chk_word("bp_hold_ct", out_ct, held);
      chk_bit("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_bit("bp_release_valid", out_valid, 1'b0);
    chk_bit("bp_release_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_bit("bp_next_accepted", busy, 1'b1);
    wait_result("bp_next", vecs[1].ct, 1'b0);
    take_result("bp_next");

    // Mid-block reset during round 5
    accept(vecs[0].pt, vecs[0].key);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_bit("midrst_out_valid", out_valid, 1'b0);
    chk_bit("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("midrst_in_ready", in_ready, 1'b1);
    chk_bit("midrst_idle_busy", busy, 1'b0);
    accept(vecs[1].pt, vecs[1].key);
    wait_result("midrst_rerun", vecs[1].ct, 1'b0);
    take_result("midrst_rerun");

    // Input churn during ROUND must not disturb the block
    accept(vecs[0].pt, vecs[0].key);
    wait_result("churn", vecs[0].ct, 1'b1);
    take_result("churn");

`ifdef AES_ABORT_EN
    // Abort during round 3, then abort coinciding with an accept is ignored
    accept(vecs[0].pt, vecs[0].key);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_bit("abort_out_valid", out_valid, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_in_ready", in_ready, 1'b1);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        seen |= out_valid;
      end
      chk_bit("abort_no_result", seen, 1'b0);
    end
    abort = 1'b1;
    accept(vecs[1].pt, vecs[1].key);
    abort = 1'b0;
    chk_bit("abort_idle_ignored", busy, 1'b1);
    wait_result("abort_rerun", vecs[1].ct, 1'b0);
    take_result("abort_rerun");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
